// File: rtl/sobel_window_gen_if.sv
// Pixel-in / window-out stream bundle for sobel_window_gen.
// slave = the window generator, master = pixel source plus window sink.
// SOBEL_WIN_COORD_EN adds the win_row/win_col window-centre coordinates.
interface sobel_window_gen_if #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480
);
  logic [PIX_W-1:0]   pix_in;
  logic               pix_sof;
  logic               pix_valid;
  logic               pix_ready;
  logic [9*PIX_W-1:0] win_out;
  logic               win_valid;
  logic               win_ready;
  logic               win_last;
  logic               frame_done;
`ifdef SOBEL_WIN_COORD_EN
  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);
  logic [ROW_W-1:0]   win_row;
  logic [COL_W-1:0]   win_col;
`endif

  modport slave (
    input  pix_in, pix_sof, pix_valid, win_ready,
    output pix_ready, win_out, win_valid, win_last, frame_done
`ifdef SOBEL_WIN_COORD_EN
    , output win_row, win_col
`endif
  );

  modport master (
    output pix_in, pix_sof, pix_valid, win_ready,
    input  pix_ready, win_out, win_valid, win_last, frame_done
`ifdef SOBEL_WIN_COORD_EN
    , input win_row, win_col
`endif
  );
endinterface

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 neighbourhood generator for the Sobel stage.
// Two line buffers hold the previous two rows; one window is issued per
// interior pixel, column-major, top-left pixel in the MSBs.
// Optional macro SOBEL_WIN_COORD_EN adds registered window-centre outputs.
module sobel_window_gen #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480
) (
  input logic                clk,
  input logic                reset,
  sobel_window_gen_if.slave  bus
);
  localparam int unsigned COL_W  = $clog2(IMG_W);
  localparam int unsigned ROW_W  = $clog2(IMG_H);
  localparam int unsigned COLS_W = 3 * PIX_W;
  localparam int unsigned WIN_W  = 9 * PIX_W;

  typedef enum logic {FILL, STREAM} state_t;

  state_t              state_q, state_d;
  logic [COL_W-1:0]    in_col, cur_col;
  logic [ROW_W-1:0]    in_row, cur_row;
  logic [PIX_W-1:0]    lb0 [IMG_W];
  logic [PIX_W-1:0]    lb1 [IMG_W];
  logic [COLS_W-1:0]   col_old, col_new, new_col;
  logic [WIN_W-1:0]    win_out_q;
  logic                win_valid_q, win_last_q, frame_done_q;
  logic                pix_ready, accept, row_end, last_pix, issue;

  assign pix_ready      = !win_valid_q || bus.win_ready;
  assign bus.pix_ready  = pix_ready;
  assign bus.win_out    = win_out_q;
  assign bus.win_valid  = win_valid_q;
  assign bus.win_last   = win_last_q;
  assign bus.frame_done = frame_done_q;

  // Position of the pixel on the bus (SOF forces 0,0) and its new window column
  always_comb begin
    accept   = bus.pix_valid && pix_ready;
    cur_col  = bus.pix_sof ? '0 : in_col;
    cur_row  = bus.pix_sof ? '0 : in_row;
    row_end  = (cur_col == COL_W'(IMG_W - 1));
    last_pix = row_end && (cur_row == ROW_W'(IMG_H - 1));
    new_col  = {lb1[cur_col], lb0[cur_col], bus.pix_in};
  end

  // Next state and window-issue decision
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      FILL: begin
        if (accept && row_end && (cur_row == ROW_W'(1))) state_d = STREAM;
      end
      STREAM: begin
        if (accept) begin
          issue = (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
          if (bus.pix_sof || last_pix) state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= FILL;
    else       state_q <= state_d;
  end

  // Raster position of the next expected pixel
  always_ff @(posedge clk) begin
    if (reset) begin
      in_col <= '0;
      in_row <= '0;
    end else if (accept) begin
      if (row_end) begin
        in_col <= '0;
        in_row <= last_pix ? '0 : cur_row + ROW_W'(1);
      end else begin
        in_col <= cur_col + COL_W'(1);
        in_row <= cur_row;
      end
    end
  end

  // Line buffers and the two previous window columns; rewritten before use, so no reset
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      lb1[cur_col] <= lb0[cur_col];
      lb0[cur_col] <= bus.pix_in;
      col_old      <= col_new;
      col_new      <= new_col;
    end
  end

  // Window output register with hold-while-stalled and frame-done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      win_out_q    <= '0;
      win_valid_q  <= 1'b0;
      win_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= accept && last_pix;
      if (issue) begin
        win_out_q   <= {col_old, col_new, new_col};
        win_valid_q <= 1'b1;
        win_last_q  <= last_pix;
      end else if (bus.win_ready) begin
        win_valid_q <= 1'b0;
        win_last_q  <= 1'b0;
      end
    end
  end

`ifdef SOBEL_WIN_COORD_EN
  logic [ROW_W-1:0] win_row_q;
  logic [COL_W-1:0] win_col_q;

  assign bus.win_row = win_row_q;
  assign bus.win_col = win_col_q;

  // Window centre coordinates travel with the window data
  always_ff @(posedge clk) begin
    if (reset) begin
      win_row_q <= '0;
      win_col_q <= '0;
    end else if (issue) begin
      win_row_q <= cur_row - ROW_W'(1);
      win_col_q <= cur_col - COL_W'(1);
    end
  end
`endif
endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen on a 4x4 image: directed table, stall, SOF,
// reset and randomized two-frame sequences against an image-array model.
module tb_sobel_window_gen;
  localparam int unsigned PIX_W = 8;
  localparam int unsigned IMG_W = 4;
  localparam int unsigned IMG_H = 4;
  localparam int unsigned WIN_W = 9 * PIX_W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sobel_window_gen_if #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) bus ();
  sobel_window_gen #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [WIN_W-1:0] act, input logic [WIN_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WIN_W-1:0] pk(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    return {PIX_W'(a0), PIX_W'(a1), PIX_W'(a2), PIX_W'(a3), PIX_W'(a4),
            PIX_W'(a5), PIX_W'(a6), PIX_W'(a7), PIX_W'(a8)};
  endfunction

  // Reference model: the image as received, addressed by raster position
  typedef struct {
    logic [WIN_W-1:0] win;
    logic             last;
    int               r;
    int               c;
  } exp_t;

  logic [PIX_W-1:0] img [IMG_H][IMG_W];
  exp_t q[$];
  int   m_r = 0, m_c = 0;
  bit   exp_valid_next = 0, fd_next = 0, held = 0;
  int   n_win = 0, n_last = 0, n_fd = 0;

  always @(negedge clk) begin
    exp_t e;
    int r, c;
    if (exp_valid_next) chk("win_latency", WIN_W'(bus.win_valid), WIN_W'(1));
    if (held)           chk("win_hold_valid", WIN_W'(bus.win_valid), WIN_W'(1));
    exp_valid_next = 0;
    chk("frame_done", WIN_W'(bus.frame_done), WIN_W'(fd_next));
    if (bus.frame_done === 1'b1) n_fd++;
    fd_next = 0;
    held = (bus.win_valid === 1'b1) && !bus.win_ready && !reset;
    if (bus.win_valid === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL win_unexpected: got win_valid=1 expected 0");
      end else begin
        e = q[0];
        chk("win_out", bus.win_out, e.win);
        chk("win_last", WIN_W'(bus.win_last), WIN_W'(e.last));
`ifdef SOBEL_WIN_COORD_EN
        chk("win_row", WIN_W'(bus.win_row), WIN_W'(e.r));
        chk("win_col", WIN_W'(bus.win_col), WIN_W'(e.c));
`endif
        if (bus.win_ready) begin
          void'(q.pop_front());
          n_win++;
          if (e.last) n_last++;
        end
      end
    end
    if (reset) begin
      q.delete();
      m_r = 0;
      m_c = 0;
      held = 0;
    end else if (bus.pix_valid && bus.pix_ready) begin
      if (bus.pix_sof) begin
        m_r = 0;
        m_c = 0;
      end
      r = m_r;
      c = m_c;
      img[r][c] = bus.pix_in;
      if (r >= 2 && c >= 2) begin
        e.win  = {img[r-2][c-2], img[r-1][c-2], img[r][c-2],
                  img[r-2][c-1], img[r-1][c-1], img[r][c-1],
                  img[r-2][c],   img[r-1][c],   img[r][c]};
        e.last = (r == IMG_H - 1) && (c == IMG_W - 1);
        e.r    = r - 1;
        e.c    = c - 1;
        q.push_back(e);
        exp_valid_next = 1;
      end
      if (r == IMG_H - 1 && c == IMG_W - 1) fd_next = 1;
      m_c = c + 1;
      if (m_c == IMG_W) begin
        m_c = 0;
        m_r = (r + 1) % IMG_H;
      end
    end
  end

  // Drivers: inputs change 1 time unit after the rising edge
  task automatic send(input logic [PIX_W-1:0] v, input logic sof);
    logic acc;
    int   guard;
    acc = 1'b0;
    guard = 0;
    bus.pix_valid = 1'b1;
    bus.pix_in    = v;
    bus.pix_sof   = sof;
    while (!acc && guard < 50) begin
      @(negedge clk);
      acc = bus.pix_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got pix_ready=0 for %0d cycles expected 1", guard);
    end
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.pix_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic             valid;
    logic             sof;
    logic [PIX_W-1:0] pix;
    logic             exp_wv;
    logic [WIN_W-1:0] exp_win;
    logic             exp_last;
    logic             exp_fd;
    int               exp_r;
    int               exp_c;
  } vec_t;

  vec_t tbl [17];
  bit   rnd_done;
  int   w0, l0, f0;

  initial begin
    reset = 1'b1;
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    bus.pix_in    = '0;
    bus.win_ready = 1'b1;

    for (int k = 0; k < 17; k++) begin
      tbl[k].valid    = (k < 16);
      tbl[k].sof      = (k == 0);
      tbl[k].pix      = PIX_W'(k);
      tbl[k].exp_wv   = 1'b0;
      tbl[k].exp_win  = '0;
      tbl[k].exp_last = 1'b0;
      tbl[k].exp_fd   = 1'b0;
      tbl[k].exp_r    = 0;
      tbl[k].exp_c    = 0;
    end
    tbl[10].exp_wv = 1; tbl[10].exp_win = pk(0, 4, 8, 1, 5, 9, 2, 6, 10);
    tbl[10].exp_r = 1;  tbl[10].exp_c = 1;
    tbl[11].exp_wv = 1; tbl[11].exp_win = pk(1, 5, 9, 2, 6, 10, 3, 7, 11);
    tbl[11].exp_r = 1;  tbl[11].exp_c = 2;
    tbl[14].exp_wv = 1; tbl[14].exp_win = pk(4, 8, 12, 5, 9, 13, 6, 10, 14);
    tbl[14].exp_r = 2;  tbl[14].exp_c = 1;
    tbl[15].exp_wv = 1; tbl[15].exp_win = pk(5, 9, 13, 6, 10, 14, 7, 11, 15);
    tbl[15].exp_r = 2;  tbl[15].exp_c = 2;
    tbl[15].exp_last = 1; tbl[15].exp_fd = 1;

    // Reset values
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("rst_pix_ready", WIN_W'(bus.pix_ready), WIN_W'(1));
    chk("rst_win_out", bus.win_out, '0);
    chk("rst_win_valid", WIN_W'(bus.win_valid), WIN_W'(0));
    chk("rst_win_last", WIN_W'(bus.win_last), WIN_W'(0));
    chk("rst_frame_done", WIN_W'(bus.frame_done), WIN_W'(0));
    reset = 1'b0;

    // Scenario 1: one clean frame, cycle-exact table
    for (int k = 0; k < 17; k++) begin
      bus.pix_valid = tbl[k].valid;
      bus.pix_sof   = tbl[k].sof;
      bus.pix_in    = tbl[k].pix;
      @(posedge clk);
      #1;
      chk($sformatf("t%0d_pix_ready", k), WIN_W'(bus.pix_ready), WIN_W'(1));
      chk($sformatf("t%0d_win_valid", k), WIN_W'(bus.win_valid), WIN_W'(tbl[k].exp_wv));
      chk($sformatf("t%0d_win_last", k), WIN_W'(bus.win_last), WIN_W'(tbl[k].exp_last));
      chk($sformatf("t%0d_frame_done", k), WIN_W'(bus.frame_done), WIN_W'(tbl[k].exp_fd));
      if (tbl[k].exp_wv) begin
        chk($sformatf("t%0d_win_out", k), bus.win_out, tbl[k].exp_win);
`ifdef SOBEL_WIN_COORD_EN
        chk($sformatf("t%0d_win_row", k), WIN_W'(bus.win_row), WIN_W'(tbl[k].exp_r));
        chk($sformatf("t%0d_win_col", k), WIN_W'(bus.win_col), WIN_W'(tbl[k].exp_c));
`endif
      end
    end
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;

    // Scenario 2: downstream stall for 5 cycles on the first window
    w0 = n_win; l0 = n_last; f0 = n_fd;
    bus.win_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 16; i++) send(PIX_W'(i), i == 0);
      end
      begin
        int g;
        g = 0;
        while (bus.win_valid !== 1'b1 && g < 200) begin
          @(posedge clk);
          #1;
          g++;
        end
        for (int k = 0; k < 5; k++) begin
          chk("s2_hold_valid", WIN_W'(bus.win_valid), WIN_W'(1));
          chk("s2_hold_ready", WIN_W'(bus.pix_ready), WIN_W'(0));
          chk("s2_hold_win", bus.win_out, pk(0, 4, 8, 1, 5, 9, 2, 6, 10));
          @(posedge clk);
          #1;
        end
        bus.win_ready = 1'b1;
      end
    join
    idle(4);
    chk("s2_windows", WIN_W'(n_win - w0), WIN_W'(4));
    chk("s2_last", WIN_W'(n_last - l0), WIN_W'(1));
    chk("s2_frame_done", WIN_W'(n_fd - f0), WIN_W'(1));

    // Scenario 3: frame A abandoned by SOF at its pixel 7, then frame B
    w0 = n_win; l0 = n_last; f0 = n_fd;
    for (int i = 0; i < 7; i++) send(PIX_W'(i), i == 0);
    for (int i = 0; i < 16; i++) begin
      send(PIX_W'(100 + i), i == 0);
      if (i == 10) begin
        chk("s3_first_valid", WIN_W'(bus.win_valid), WIN_W'(1));
        chk("s3_first_win", bus.win_out, pk(100, 104, 108, 101, 105, 109, 102, 106, 110));
      end
    end
    idle(4);
    chk("s3_windows", WIN_W'(n_win - w0), WIN_W'(4));
    chk("s3_frame_done", WIN_W'(n_fd - f0), WIN_W'(1));

    // Scenario 4: reset after pixel 11, then a frame without SOF
    for (int i = 0; i < 12; i++) send(PIX_W'(i), i == 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("s4_pix_ready", WIN_W'(bus.pix_ready), WIN_W'(1));
    chk("s4_win_out", bus.win_out, '0);
    chk("s4_win_valid", WIN_W'(bus.win_valid), WIN_W'(0));
    chk("s4_win_last", WIN_W'(bus.win_last), WIN_W'(0));
    chk("s4_frame_done", WIN_W'(bus.frame_done), WIN_W'(0));
`ifdef SOBEL_WIN_COORD_EN
    chk("s4_win_row", WIN_W'(bus.win_row), '0);
    chk("s4_win_col", WIN_W'(bus.win_col), '0);
`endif
    reset = 1'b0;
    w0 = n_win; l0 = n_last; f0 = n_fd;
    for (int i = 0; i < 16; i++) send(PIX_W'(200 + i), 1'b0);
    idle(4);
    chk("s4_windows", WIN_W'(n_win - w0), WIN_W'(4));
    chk("s4_last", WIN_W'(n_last - l0), WIN_W'(1));
    chk("s4_fd", WIN_W'(n_fd - f0), WIN_W'(1));

    // Scenario 5: two random frames with random valid gaps and ready stalls
    w0 = n_win; l0 = n_last; f0 = n_fd;
    rnd_done = 0;
    fork
      begin
        for (int f = 0; f < 2; f++)
          for (int i = 0; i < 16; i++) begin
            idle($urandom_range(0, 2));
            send(PIX_W'($urandom), i == 0);
          end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          bus.win_ready = ($urandom_range(0, 3) != 0);
        end
        bus.win_ready = 1'b1;
      end
    join
    idle(6);
    chk("s5_windows", WIN_W'(n_win - w0), WIN_W'(8));
    chk("s5_last", WIN_W'(n_last - l0), WIN_W'(2));
    chk("s5_fd", WIN_W'(n_fd - f0), WIN_W'(2));
    chk("sb_empty", WIN_W'(q.size()), WIN_W'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
